// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter
//   Shares the single VGA framebuffer plot port among NUM_REQ drawing engines
//   (lane scroller, score digits, screen clear). One owner at a time through a
//   level req / registered one-hot gnt handshake. The owner's pixel is
//   registered onto the vga_* outputs, so vga_plot follows req_plot by one
//   cycle. A hold-time watchdog revokes a grant that lasts MAX_HOLD cycles.
//   frame_done pulses once when all granted draw work has drained, and the
//   song FSM uses it as its ready-for-song.
//
//   Optional feature: define DRAW_ARB_ROUND_ROBIN_EN for circular arbitration
//   that starts after the last owner. Without it, arbitration is fixed
//   priority and the lowest index wins.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   req         in   [NUM_REQ]        per-requester draw request (level)
//   req_x       in   [NUM_REQ*X_W]    packed x, slice i = requester i
//   req_y       in   [NUM_REQ*Y_W]    packed y
//   req_col     in   [NUM_REQ*COL_W]  packed colour
//   req_plot    in   [NUM_REQ]        per-requester pixel-write strobe
//   err_clear   in   clears timeout_err
//   gnt         out  [NUM_REQ]        one-hot grant, registered
//   vga_x/y/col out  pixel to the VGA adapter
//   vga_plot    out  write strobe to the VGA adapter
//   frame_done  out  1-cycle pulse when all draw work has drained
//   timeout_err out  sticky, set when the watchdog revokes a grant
module draw_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COL_W    = 3,
   parameter int MAX_HOLD = 20000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*X_W-1:0]   req_x,
   input  logic [NUM_REQ*Y_W-1:0]   req_y,
   input  logic [NUM_REQ*COL_W-1:0] req_col,
   input  logic [NUM_REQ-1:0]       req_plot,
   input  logic                     err_clear,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [X_W-1:0]           vga_x,
   output logic [Y_W-1:0]           vga_y,
   output logic [COL_W-1:0]         vga_col,
   output logic                     vga_plot,
   output logic                     frame_done,
   output logic                     timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               served_q, served_d;
   logic [NUM_REQ-1:0] armed_q, armed_d;
   logic               timeout_q, timeout_d;
   logic [X_W-1:0]     vga_x_q, vga_x_d;
   logic [Y_W-1:0]     vga_y_q, vga_y_d;
   logic [COL_W-1:0]   vga_col_q, vga_col_d;
   logic               vga_plot_q, vga_plot_d;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]   last_q, last_d;
`endif

   logic [X_W-1:0]     x_arr   [NUM_REQ];
   logic [Y_W-1:0]     y_arr   [NUM_REQ];
   logic [COL_W-1:0]   col_arr [NUM_REQ];
   logic [NUM_REQ-1:0] eff_req;
   logic               any_eff;
   logic [IDX_W-1:0]   winner;
   logic               owner_req;
   logic               at_limit;
   logic               revoke;

   // Unpack the per-requester pixel buses so the owner can be indexed directly.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         x_arr[i]   = req_x[i*X_W +: X_W];
         y_arr[i]   = req_y[i*Y_W +: Y_W];
         col_arr[i] = req_col[i*COL_W +: COL_W];
      end
   end

   // A requester revoked by the watchdog is ignored until it drops req once.
   assign eff_req   = req & armed_q;
   assign any_eff   = |eff_req;
   assign owner_req = req[owner_q];
   assign at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
   // A normal release in the same cycle takes precedence over the watchdog.
   assign revoke    = (state_q == GRANT) && owner_req && at_limit;

   always_comb begin
      winner = '0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
      // Walk backwards so the requester closest after last_q wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (eff_req[idx]) winner = idx;
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eff_req[i]) winner = IDX_W'(i);
      end
`endif
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         gnt_q      <= '0;
         cnt_q      <= '0;
         served_q   <= 1'b0;
         armed_q    <= '1;
         timeout_q  <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         vga_col_q  <= '0;
         vga_plot_q <= 1'b0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
         last_q     <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         cnt_q      <= cnt_d;
         served_q   <= served_d;
         armed_q    <= armed_d;
         timeout_q  <= timeout_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         vga_col_q  <= vga_col_d;
         vga_plot_q <= vga_plot_d;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_eff) state_d = GRANT;
         GRANT:   if (!owner_req || at_limit) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      served_d   = served_q;
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      vga_col_d  = vga_col_q;
      vga_plot_d = 1'b0;
      frame_done = 1'b0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif

      armed_d = armed_q | ~req;
      if (revoke) armed_d[owner_q] = 1'b0;

      if (revoke)         timeout_d = 1'b1;
      else if (err_clear) timeout_d = 1'b0;
      else                timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (any_eff) begin
               owner_d         = winner;
               gnt_d           = '0;
               gnt_d[winner]   = 1'b1;
               served_d        = 1'b1;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
               last_d          = winner;
`endif
            end else if (req == '0 && served_q) begin
               // Pending work only counts as drained when nobody is asking,
               // including a revoked requester that has not yet re-armed.
               frame_done = 1'b1;
               served_d   = 1'b0;
            end
         end
         GRANT: begin
            vga_x_d    = x_arr[owner_q];
            vga_y_d    = y_arr[owner_q];
            vga_col_d  = col_arr[owner_q];
            vga_plot_d = req_plot[owner_q];
            if (!owner_req || at_limit) begin
               gnt_d = '0;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            gnt_d = '0;
            cnt_d = '0;
         end
      endcase
   end

   assign gnt         = gnt_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_col     = vga_col_q;
   assign vga_plot    = vga_plot_q;
   assign timeout_err = timeout_q;

endmodule
